serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_if.sv | 36 +++
 rtl/serial_subtractor.sv | 122 ++++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor; master drives start/a/b, slave returns results.
// Optional signed-overflow flag ovf is present only when SUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int unsigned W = 4
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] diff;
  logic         borrow;
  logic         busy;
  logic         done;
`ifdef SUB_OVF_EN
  logic         ovf;

  modport master (
    output start, a, b,
    input  diff, borrow, busy, done, ovf
  );

  modport slave (
    input  start, a, b,
    output diff, borrow, busy, done, ovf
  );
`else
  modport master (
    output start, a, b,
    input  diff, borrow, busy, done
  );

  modport slave (
    input  start, a, b,
    output diff, borrow, busy, done
  );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor: one bit per RUN cycle, LSB first, result valid in DONE.
// Define SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor #(
  parameter int unsigned W = 4
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CntW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [W-1:0]    a_sr_q, a_sr_d;
  logic [W-1:0]    b_sr_q, b_sr_d;
  logic [W-1:0]    diff_q, diff_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            bin_q, bin_d;
  logic            borrow_q, borrow_d;
`ifdef SUB_OVF_EN
  logic            ovf_q, ovf_d;
`endif

  logic ai, bi, d, bout;

  // Full-subtractor cell on the current LSB of the rotating operand registers.
  always_comb begin
    ai   = a_sr_q[0];
    bi   = b_sr_q[0];
    d    = ai ^ bi ^ bin_q;
    bout = (~ai & bi) | (~(ai ^ bi) & bin_q);
  end

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    borrow_d = borrow_q;
`ifdef SUB_OVF_EN
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          cnt_d   = '0;
          bin_d   = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        // Rotate rather than shift so the captured operands are intact after W cycles.
        a_sr_d = {a_sr_q[0], a_sr_q[W-1:1]};
        b_sr_d = {b_sr_q[0], b_sr_q[W-1:1]};
        diff_d = {d, diff_q[W-1:1]};
        bin_d  = bout;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          borrow_d = bout;
`ifdef SUB_OVF_EN
          // On the last bit ai/bi are the operand sign bits and d is the result sign bit.
          ovf_d    = (ai != bi) && (d != ai);
`endif
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      borrow_q <= borrow_d;
    end
  end

`ifdef SUB_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
  assign bus.busy   = (state_q == StRun) || (state_q == StDone);
  assign bus.done   = (state_q == StDone);

endmodule
